id_ex_stage: RTL and testbench

- ID/EX pipeline boundary directly downstream of the control unit.
- Registers the control bundle decoded in ID together with operand data, PC, immediate and register addresses, and presents them to EX.
- Detects load-use hazards, inserts a bubble and raises a stall to IF/ID.
- Squashes the in-flight ID instruction on a taken branch or jump resolved in EX.
- Keeps saturating stall and flush event counters.

---
 rtl/id_ex_stage_pkg.sv | 75 +++++++
 rtl/id_ex_stage_hazard_detect.sv | 36 +++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode enums and the ID/EX control bundle.
// CTRL_BUBBLE is the single definition of a NOP control word.
package id_ex_stage_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [2:0] {
    BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } comp_op_t;

  typedef enum logic [1:0] {
    WRSRC_ALURES, WRSRC_MEM, WRSRC_PC4
  } reg_wr_src_t;

  typedef enum logic [1:0] {
    SRC1_REG1, SRC1_PC, SRC1_ZERO
  } alu_src1_t;

  typedef enum logic [1:0] {
    SRC2_REG2, SRC2_IMM, SRC2_FOUR
  } alu_src2_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_t;

  typedef enum logic [2:0] {
    MEM_NOP, MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU
  } mem_op_t;

  typedef struct packed {
    logic        reg_do_write;
    logic        mem_do_write;
    logic        mem_do_read;
    logic        do_branch;
    logic        do_jump;
    comp_op_t    comp;
    reg_wr_src_t reg_wr_src;
    alu_src1_t   alu_src1;
    alu_src2_t   alu_src2;
    alu_op_t     alu;
    mem_op_t     mem;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '{
    reg_do_write: 1'b0,
    mem_do_write: 1'b0,
    mem_do_read:  1'b0,
    do_branch:    1'b0,
    do_jump:      1'b0,
    comp:         BR_NOP,
    reg_wr_src:   WRSRC_ALURES,
    alu_src1:     SRC1_REG1,
    alu_src2:     SRC2_REG2,
    alu:          ALU_NOP,
    mem:          MEM_NOP
  };

  // Invalid slots must never carry side-effecting control into EX.
  function automatic ctrl_bundle_t ctrl_or_bubble(input logic valid, input ctrl_bundle_t c);
    return valid ? c : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_id_valid,
  input  alu_src1_t             i_alu_src1,
  input  alu_src2_t             i_alu_src2,
  input  alu_op_t               i_alu_op,
  input  logic                  i_mem_do_write,
  input  logic                  i_do_branch,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_do_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  output logic                  o_hazard_c
);

  logic w_use_rs1;
  logic w_use_rs2;
  logic w_ex_load;

  // LUI ignores rs1 even though its source select may default to REG1.
  assign w_use_rs1 = i_id_valid && (i_alu_op != ALU_LUI) &&
                     ((i_alu_src1 == SRC1_REG1) || i_do_branch);
  assign w_use_rs2 = i_id_valid &&
                     ((i_alu_src2 == SRC2_REG2) || i_mem_do_write || i_do_branch);
  assign w_ex_load = i_ex_valid && i_ex_mem_do_read && (i_ex_rd_addr != '0);

  assign o_hazard_c = w_ex_load &&
                      ((w_use_rs1 && (i_rs1_addr == i_ex_rd_addr)) ||
                       (w_use_rs2 && (i_rs2_addr == i_ex_rd_addr)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-resolved squash
// and saturating stall/flush event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_reg_do_write_ctrl,
  input  logic                  id_mem_do_write_ctrl,
  input  logic                  id_mem_do_read_ctrl,
  input  logic                  id_do_branch,
  input  logic                  id_do_jump,
  input  comp_op_t              id_comp_ctrl,
  input  reg_wr_src_t           id_reg_wr_src_ctrl,
  input  alu_src1_t             id_alu_src1_ctrl,
  input  alu_src2_t             id_alu_src2_ctrl,
  input  alu_op_t               id_alu_ctrl,
  input  mem_op_t               id_mem_ctrl,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  ex_flush,
  output logic                  ex_valid,
  output logic                  ex_reg_do_write_ctrl,
  output logic                  ex_mem_do_write_ctrl,
  output logic                  ex_mem_do_read_ctrl,
  output logic                  ex_do_branch,
  output logic                  ex_do_jump,
  output comp_op_t              ex_comp_ctrl,
  output reg_wr_src_t           ex_reg_wr_src_ctrl,
  output alu_src1_t             ex_alu_src1_ctrl,
  output alu_src2_t             ex_alu_src2_ctrl,
  output alu_op_t               ex_alu_ctrl,
  output mem_op_t               ex_mem_ctrl,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_bundle_t          w_id_ctrl;
  logic                  w_hazard;
  logic                  w_stall;
  ctrl_bundle_t          r_ctrl;
  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]      r_stall_count;
  logic [CNT_W-1:0]      r_flush_count;

  assign w_id_ctrl = '{
    reg_do_write: id_reg_do_write_ctrl,
    mem_do_write: id_mem_do_write_ctrl,
    mem_do_read:  id_mem_do_read_ctrl,
    do_branch:    id_do_branch,
    do_jump:      id_do_jump,
    comp:         id_comp_ctrl,
    reg_wr_src:   id_reg_wr_src_ctrl,
    alu_src1:     id_alu_src1_ctrl,
    alu_src2:     id_alu_src2_ctrl,
    alu:          id_alu_ctrl,
    mem:          id_mem_ctrl
  };

  id_ex_stage_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .i_id_valid       (id_valid),
    .i_alu_src1       (id_alu_src1_ctrl),
    .i_alu_src2       (id_alu_src2_ctrl),
    .i_alu_op         (id_alu_ctrl),
    .i_mem_do_write   (id_mem_do_write_ctrl),
    .i_do_branch      (id_do_branch),
    .i_rs1_addr       (id_rs1_addr),
    .i_rs2_addr       (id_rs2_addr),
    .i_ex_valid       (r_valid),
    .i_ex_mem_do_read (r_ctrl.mem_do_read),
    .i_ex_rd_addr     (r_rd_addr),
    .o_hazard_c       (w_hazard)
  );

  // A squash makes the stalled ID instruction irrelevant, so flush wins.
  assign w_stall = w_hazard && !ex_flush;
  assign stall   = w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_ctrl        <= CTRL_BUBBLE;
      r_pc          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rd_addr     <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (ex_flush || w_stall) begin
        r_valid    <= 1'b0;
        r_ctrl     <= CTRL_BUBBLE;
        r_pc       <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_rs1_addr <= '0;
        r_rs2_addr <= '0;
        r_rd_addr  <= '0;
      end else begin
        r_valid    <= id_valid;
        r_ctrl     <= ctrl_or_bubble(id_valid, w_id_ctrl);
        r_pc       <= id_pc;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
        r_rs1_addr <= id_rs1_addr;
        r_rs2_addr <= id_rs2_addr;
        r_rd_addr  <= id_rd_addr;
      end
      if (ex_flush && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
      if (w_stall && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign ex_valid             = r_valid;
  assign ex_reg_do_write_ctrl = r_ctrl.reg_do_write;
  assign ex_mem_do_write_ctrl = r_ctrl.mem_do_write;
  assign ex_mem_do_read_ctrl  = r_ctrl.mem_do_read;
  assign ex_do_branch         = r_ctrl.do_branch;
  assign ex_do_jump           = r_ctrl.do_jump;
  assign ex_comp_ctrl         = r_ctrl.comp;
  assign ex_reg_wr_src_ctrl   = r_ctrl.reg_wr_src;
  assign ex_alu_src1_ctrl     = r_ctrl.alu_src1;
  assign ex_alu_src2_ctrl     = r_ctrl.alu_src2;
  assign ex_alu_ctrl          = r_ctrl.alu;
  assign ex_mem_ctrl          = r_ctrl.mem;
  assign ex_pc                = r_pc;
  assign ex_rs1_data          = r_rs1_data;
  assign ex_rs2_data          = r_rs2_data;
  assign ex_imm               = r_imm;
  assign ex_rs1_addr          = r_rs1_addr;
  assign ex_rs2_addr          = r_rs2_addr;
  assign ex_rd_addr           = r_rd_addr;
  assign stall_count          = r_stall_count;
  assign flush_count          = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: expected EX contents are queued when a
// vector is driven and compared after the capturing edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         id_valid, ex_flush;
  ctrl_bundle_t id_ctrl;
  logic [31:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;

  logic         ex_valid, ex_reg_do_write_ctrl, ex_mem_do_write_ctrl, ex_mem_do_read_ctrl;
  logic         ex_do_branch, ex_do_jump, stall;
  comp_op_t     ex_comp_ctrl;
  reg_wr_src_t  ex_reg_wr_src_ctrl;
  alu_src1_t    ex_alu_src1_ctrl;
  alu_src2_t    ex_alu_src2_ctrl;
  alu_op_t      ex_alu_ctrl;
  mem_op_t      ex_mem_ctrl;
  logic [31:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, stall_count, flush_count;
  logic [4:0]   ex_rs1_addr, ex_rs2_addr, ex_rd_addr;

  logic         q_valid, q_reg_do_write_ctrl, q_mem_do_write_ctrl, q_mem_do_read_ctrl;
  logic         q_do_branch, q_do_jump, q_stall;
  comp_op_t     q_comp_ctrl;
  reg_wr_src_t  q_reg_wr_src_ctrl;
  alu_src1_t    q_alu_src1_ctrl;
  alu_src2_t    q_alu_src2_ctrl;
  alu_op_t      q_alu_ctrl;
  mem_op_t      q_mem_ctrl;
  logic [31:0]  q_pc, q_rs1_data, q_rs2_data, q_imm;
  logic [4:0]   q_rs1_addr, q_rs2_addr, q_rd_addr;
  logic [3:0]   q_stall_count, q_flush_count;

  id_ex_stage u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_do_write_ctrl(id_ctrl.reg_do_write), .id_mem_do_write_ctrl(id_ctrl.mem_do_write),
    .id_mem_do_read_ctrl(id_ctrl.mem_do_read), .id_do_branch(id_ctrl.do_branch),
    .id_do_jump(id_ctrl.do_jump), .id_comp_ctrl(id_ctrl.comp),
    .id_reg_wr_src_ctrl(id_ctrl.reg_wr_src), .id_alu_src1_ctrl(id_ctrl.alu_src1),
    .id_alu_src2_ctrl(id_ctrl.alu_src2), .id_alu_ctrl(id_ctrl.alu), .id_mem_ctrl(id_ctrl.mem),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .ex_flush(ex_flush), .ex_valid(ex_valid),
    .ex_reg_do_write_ctrl(ex_reg_do_write_ctrl), .ex_mem_do_write_ctrl(ex_mem_do_write_ctrl),
    .ex_mem_do_read_ctrl(ex_mem_do_read_ctrl), .ex_do_branch(ex_do_branch),
    .ex_do_jump(ex_do_jump), .ex_comp_ctrl(ex_comp_ctrl),
    .ex_reg_wr_src_ctrl(ex_reg_wr_src_ctrl), .ex_alu_src1_ctrl(ex_alu_src1_ctrl),
    .ex_alu_src2_ctrl(ex_alu_src2_ctrl), .ex_alu_ctrl(ex_alu_ctrl), .ex_mem_ctrl(ex_mem_ctrl),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter instance on the same stimulus, used for saturation.
  id_ex_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_do_write_ctrl(id_ctrl.reg_do_write), .id_mem_do_write_ctrl(id_ctrl.mem_do_write),
    .id_mem_do_read_ctrl(id_ctrl.mem_do_read), .id_do_branch(id_ctrl.do_branch),
    .id_do_jump(id_ctrl.do_jump), .id_comp_ctrl(id_ctrl.comp),
    .id_reg_wr_src_ctrl(id_ctrl.reg_wr_src), .id_alu_src1_ctrl(id_ctrl.alu_src1),
    .id_alu_src2_ctrl(id_ctrl.alu_src2), .id_alu_ctrl(id_ctrl.alu), .id_mem_ctrl(id_ctrl.mem),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .ex_flush(ex_flush), .ex_valid(q_valid),
    .ex_reg_do_write_ctrl(q_reg_do_write_ctrl), .ex_mem_do_write_ctrl(q_mem_do_write_ctrl),
    .ex_mem_do_read_ctrl(q_mem_do_read_ctrl), .ex_do_branch(q_do_branch),
    .ex_do_jump(q_do_jump), .ex_comp_ctrl(q_comp_ctrl),
    .ex_reg_wr_src_ctrl(q_reg_wr_src_ctrl), .ex_alu_src1_ctrl(q_alu_src1_ctrl),
    .ex_alu_src2_ctrl(q_alu_src2_ctrl), .ex_alu_ctrl(q_alu_ctrl), .ex_mem_ctrl(q_mem_ctrl),
    .ex_pc(q_pc), .ex_rs1_data(q_rs1_data), .ex_rs2_data(q_rs2_data), .ex_imm(q_imm),
    .ex_rs1_addr(q_rs1_addr), .ex_rs2_addr(q_rs2_addr), .ex_rd_addr(q_rd_addr),
    .stall(q_stall), .stall_count(q_stall_count), .flush_count(q_flush_count)
  );

  ctrl_bundle_t act_ctrl;
  assign act_ctrl = {ex_reg_do_write_ctrl, ex_mem_do_write_ctrl, ex_mem_do_read_ctrl,
                     ex_do_branch, ex_do_jump, ex_comp_ctrl, ex_reg_wr_src_ctrl,
                     ex_alu_src1_ctrl, ex_alu_src2_ctrl, ex_alu_ctrl, ex_mem_ctrl};

  typedef struct packed {
    logic         valid;
    logic         flush;
    ctrl_bundle_t ctrl;
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  imm;
    logic         exp_stall;
  } vec_t;

  typedef struct packed {
    logic         valid;
    ctrl_bundle_t ctrl;
    logic [31:0]  pc, d1, d2, imm;
    logic [14:0]  addrs;
    logic [31:0]  sc, fc;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        tbl[$];
  int unsigned m_sc, m_fc;
  int          total = 0;
  int          bad = 0;

  function automatic ctrl_bundle_t c_rtype(input alu_op_t op);
    ctrl_bundle_t c;
    c = CTRL_BUBBLE;
    c.reg_do_write = 1'b1;
    c.alu = op;
    return c;
  endfunction

  function automatic ctrl_bundle_t c_itype(input alu_op_t op);
    ctrl_bundle_t c;
    c = c_rtype(op);
    c.alu_src2 = SRC2_IMM;
    return c;
  endfunction

  function automatic ctrl_bundle_t c_load();
    ctrl_bundle_t c;
    c = c_itype(ALU_ADD);
    c.mem_do_read = 1'b1;
    c.reg_wr_src = WRSRC_MEM;
    c.mem = MEM_W;
    return c;
  endfunction

  function automatic ctrl_bundle_t c_store();
    ctrl_bundle_t c;
    c = CTRL_BUBBLE;
    c.mem_do_write = 1'b1;
    c.alu = ALU_ADD;
    c.alu_src2 = SRC2_IMM;
    c.mem = MEM_W;
    return c;
  endfunction

  // Branch target uses PC+imm, so only do_branch marks rs1/rs2 as used.
  function automatic ctrl_bundle_t c_branch();
    ctrl_bundle_t c;
    c = CTRL_BUBBLE;
    c.do_branch = 1'b1;
    c.comp = BR_EQ;
    c.alu = ALU_ADD;
    c.alu_src1 = SRC1_PC;
    c.alu_src2 = SRC2_IMM;
    return c;
  endfunction

  function automatic vec_t mk(input logic v, input logic f, input ctrl_bundle_t c,
                              input int a1, input int a2, input int rd,
                              input logic [31:0] imm, input logic st);
    vec_t r;
    r.valid = v; r.flush = f; r.ctrl = c;
    r.rs1 = 5'(a1); r.rs2 = 5'(a2); r.rd = 5'(rd);
    r.imm = imm; r.exp_stall = st;
    return r;
  endfunction

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  task automatic compare_ex(input int id);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty vec=%0d got=0 expected=1", id);
    end else begin
      e = exp_q.pop_front();
      chk("ex_valid", id, 64'(ex_valid), 64'(e.valid));
      chk("ex_ctrl", id, 64'(act_ctrl), 64'(e.ctrl));
      chk("ex_pc", id, 64'(ex_pc), 64'(e.pc));
      chk("ex_imm", id, 64'(ex_imm), 64'(e.imm));
      chk("ex_rs1_data", id, 64'(ex_rs1_data), 64'(e.d1));
      chk("ex_rs2_data", id, 64'(ex_rs2_data), 64'(e.d2));
      chk("ex_addrs", id, 64'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr}), 64'(e.addrs));
      chk("stall_count", id, 64'(stall_count), 64'(e.sc));
      chk("flush_count", id, 64'(flush_count), 64'(e.fc));
    end
  endtask

  task automatic step(input vec_t v, input logic [31:0] pc, input int id);
    exp_t e;
    @(negedge clk);
    id_valid    = v.valid;
    ex_flush    = v.flush;
    id_ctrl     = v.ctrl;
    id_rs1_addr = v.rs1;
    id_rs2_addr = v.rs2;
    id_rd_addr  = v.rd;
    id_imm      = v.imm;
    id_pc       = pc;
    id_rs1_data = 32'hA000_0000 ^ pc;
    id_rs2_data = 32'hB000_0000 ^ pc;
    #1;
    chk("stall", id, 64'(stall), 64'(v.exp_stall));
    e = '0;
    e.ctrl = CTRL_BUBBLE;
    if (v.flush) m_fc++;
    else if (v.exp_stall) m_sc++;
    else begin
      e.valid = v.valid;
      e.ctrl  = v.valid ? v.ctrl : CTRL_BUBBLE;
      e.pc    = pc;
      e.imm   = v.imm;
      e.d1    = 32'hA000_0000 ^ pc;
      e.d2    = 32'hB000_0000 ^ pc;
      e.addrs = {v.rs1, v.rs2, v.rd};
    end
    e.sc = 32'(m_sc);
    e.fc = 32'(m_fc);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_ex(id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; ex_flush = 1'b0; id_ctrl = CTRL_BUBBLE;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    m_sc = 0; m_fc = 0;

    tbl.push_back(mk(1, 0, c_rtype(ALU_ADD), 1, 2, 3, 32'd0, 0));     // ADD x3,x1,x2
    tbl.push_back(mk(1, 0, c_itype(ALU_ADD), 3, 0, 4, 32'd5, 0));     // ADDI x4,x3,5
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 5, 32'd0, 0));             // LW x5,0(x1)
    tbl.push_back(mk(1, 0, c_rtype(ALU_ADD), 5, 7, 6, 32'd0, 1));     // ADD x6,x5,x7
    tbl.push_back(mk(1, 0, c_rtype(ALU_ADD), 5, 7, 6, 32'd0, 0));     // held ADD
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 0, 32'd0, 0));             // LW x0
    tbl.push_back(mk(1, 0, c_rtype(ALU_ADD), 0, 0, 8, 32'd0, 0));     // ADD x8,x0,x0
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 5, 32'd4, 0));             // LW x5,4(x1)
    tbl.push_back(mk(1, 0, c_itype(ALU_LUI), 5, 5, 5, 32'h12345000, 0)); // LUI x5
    tbl.push_back(mk(1, 0, c_load(), 2, 0, 9, 32'd0, 0));             // LW x9
    tbl.push_back(mk(1, 0, c_store(), 3, 9, 0, 32'd8, 1));            // SW x9,8(x3)
    tbl.push_back(mk(1, 0, c_store(), 3, 9, 0, 32'd8, 0));
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 10, 32'd0, 0));            // LW x10
    tbl.push_back(mk(1, 0, c_branch(), 1, 10, 0, 32'd16, 1));         // BEQ x1,x10
    tbl.push_back(mk(1, 0, c_branch(), 1, 10, 0, 32'd16, 0));
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 15, 32'd0, 0));            // LW x15
    tbl.push_back(mk(1, 0, c_rtype(ALU_ADD), 1, 15, 16, 32'd0, 1));   // ADD x16,x1,x15
    tbl.push_back(mk(1, 0, c_rtype(ALU_ADD), 1, 15, 16, 32'd0, 0));
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 11, 32'd0, 0));            // LW x11
    tbl.push_back(mk(0, 0, c_rtype(ALU_ADD), 11, 11, 12, 32'd0, 0));  // invalid slot
    tbl.push_back(mk(1, 0, c_load(), 1, 0, 12, 32'd0, 0));            // LW x12
    tbl.push_back(mk(1, 1, c_rtype(ALU_ADD), 12, 12, 13, 32'd0, 0));  // hazard + flush
    tbl.push_back(mk(1, 0, c_itype(ALU_ADD), 1, 0, 14, 32'd1, 0));    // ADDI x14,x1,1

    @(posedge clk);
    #1;
    chk("rst_ex_valid", -1, 64'(ex_valid), 64'(0));
    chk("rst_ex_ctrl", -1, 64'(act_ctrl), 64'(CTRL_BUBBLE));
    chk("rst_counts", -1, 64'({stall_count, flush_count}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], 32'h1000 + 32'(4 * i), i);
    end
    chk("q_stall_count_mid", 99, 64'(q_stall_count), 64'(m_sc));
    chk("q_flush_count_mid", 99, 64'(q_flush_count), 64'(m_fc));

    // Async reset while a load-use stall is being raised.
    step(mk(1, 0, c_load(), 1, 0, 5, 32'd0, 0), 32'h2000, 200);
    @(negedge clk);
    id_valid = 1'b1; id_ctrl = c_rtype(ALU_ADD);
    id_rs1_addr = 5'd5; id_rs2_addr = 5'd7; id_rd_addr = 5'd6;
    #1;
    chk("pre_rst_stall", 201, 64'(stall), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_stall", 201, 64'(stall), 64'(0));
    chk("rst_ex_valid", 201, 64'(ex_valid), 64'(0));
    chk("rst_ex_ctrl", 201, 64'(act_ctrl), 64'(CTRL_BUBBLE));
    chk("rst_ex_data", 201, 64'(ex_pc ^ ex_imm ^ ex_rs1_data ^ ex_rs2_data) | 64'(ex_rd_addr), 64'(0));
    chk("rst_counts", 201, 64'({stall_count, flush_count}), 64'(0));
    chk("rst_q_counts", 201, 64'({q_stall_count, q_flush_count}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_sc = 0;
    m_fc = 0;

    for (int k = 0; k < 20; k++) begin
      step(mk(1, 0, c_load(), 1, 0, 5, 32'd0, 0), 32'h3000, 300 + k);
      step(mk(1, 0, c_rtype(ALU_ADD), 5, 7, 6, 32'd0, 1), 32'h3004, 300 + k);
      step(mk(1, 0, c_rtype(ALU_ADD), 5, 7, 6, 32'd0, 0), 32'h3004, 300 + k);
    end
    chk("q_stall_sat", 400, 64'(q_stall_count), 64'(15));
    chk("q_flush_after", 400, 64'(q_flush_count), 64'(0));
    chk("stall_count_20", 400, 64'(stall_count), 64'(20));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
